alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 142 ++++++++++++++
 tb/tb_alu_arbiter.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Two-port arbiter in front of one shared 32-bit ALU with a single result register.
// Latency: result is valid one cycle after acceptance; throughput is one op per 2 cycles.
// Backpressure: requests stall while a result is held; result holds until its owner takes it.
module alu_arbiter #(
    parameter int unsigned FIXED_PRIO = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic [2:0]  req0_op,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    input  logic [2:0]  req1_op,
    output logic        rsp0_valid,
    input  logic        rsp0_ready,
    output logic        rsp1_valid,
    input  logic        rsp1_ready,
    output logic [31:0] rsp_result,
    output logic        rsp_zero,
    output logic        rsp_err
);

    localparam logic [2:0] OP_ADDU = 3'b000;
    localparam logic [2:0] OP_SUBU = 3'b100;
    localparam logic [2:0] OP_OR   = 3'b010;
    localparam logic [2:0] OP_SLTU = 3'b110;

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_t;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  op;
    } req_t;

    typedef struct packed {
        logic [31:0] result;
        logic        zero;
        logic        err;
        logic        owner;
    } rsp_t;

    localparam rsp_t RSP_RESET = '{result: 32'd0, zero: 1'b1, err: 1'b0, owner: 1'b0};

    state_t      state_q;
    state_t      state_d;
    logic        last_gnt_q;
    rsp_t        rsp_q;
    logic        gnt0;
    logic        gnt1;
    logic        accept;
    logic        consume;
    req_t        sel_req;
    logic [31:0] alu_res;
    logic        alu_err;

    // last_gnt_q == 1 means port 1 won most recently, so port 0 takes the next tie.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (req0_valid && req1_valid) begin
            if ((FIXED_PRIO != 0) || last_gnt_q) begin
                gnt0 = 1'b1;
            end else begin
                gnt1 = 1'b1;
            end
        end else begin
            gnt0 = req0_valid;
            gnt1 = req1_valid;
        end
    end

    always_comb begin
        sel_req = gnt1 ? '{a: req1_a, b: req1_b, op: req1_op}
                       : '{a: req0_a, b: req0_b, op: req0_op};
    end

    // Illegal op codes still complete, reporting a zero result with err set.
    always_comb begin
        alu_res = 32'd0;
        alu_err = 1'b0;
        case (sel_req.op)
            OP_ADDU: alu_res = sel_req.a + sel_req.b;
            OP_SUBU: alu_res = sel_req.a - sel_req.b;
            OP_OR:   alu_res = sel_req.a | sel_req.b;
            OP_SLTU: alu_res = {31'd0, (sel_req.a < sel_req.b)};
            default: alu_err = 1'b1;
        endcase
    end

    assign accept  = (state_q == IDLE) && (gnt0 || gnt1);
    assign consume = (state_q == RESP) && (rsp_q.owner ? rsp1_ready : rsp0_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept)  state_d = RESP;
            RESP: if (consume) state_d = IDLE;
        endcase
    end

    always_comb begin
        req0_ready = (state_q == IDLE) && gnt0;
        req1_ready = (state_q == IDLE) && gnt1;
        rsp0_valid = (state_q == RESP) && !rsp_q.owner;
        rsp1_valid = (state_q == RESP) &&  rsp_q.owner;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_gnt_q <= 1'b1;
            rsp_q      <= RSP_RESET;
        end else if (accept) begin
            last_gnt_q   <= gnt1;
            rsp_q.result <= alu_res;
            rsp_q.zero   <= (alu_res == 32'd0);
            rsp_q.err    <= alu_err;
            rsp_q.owner  <= gnt1;
        end
    end

    assign rsp_result = rsp_q.result;
    assign rsp_zero   = rsp_q.zero;
    assign rsp_err    = rsp_q.err;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed and random checks of alu_arbiter (round-robin and fixed-priority builds driven in lockstep)
// against a transaction-level model of the arbiter and ALU.
module tb_alu_arbiter;

    logic        clk;
    logic        rst_n;
    logic        req0_valid, req1_valid;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [2:0]  req0_op, req1_op;
    logic        rsp0_ready, rsp1_ready;

    logic        q0rdy [2];
    logic        q1rdy [2];
    logic        q0vld [2];
    logic        q1vld [2];
    logic [31:0] qres  [2];
    logic        qzero [2];
    logic        qerr  [2];

    int ncmp  = 0;
    int nfail = 0;

    // Model: per build, whether a result is outstanding, its owner, and the last port granted.
    bit          m_busy  [2];
    int          m_own   [2];
    int          m_lastg [2];
    logic [31:0] m_res   [2];
    bit          m_zero  [2];
    bit          m_err   [2];
    int          lastobs [2];
    string       phase;

    alu_arbiter #(.FIXED_PRIO(0)) dut_rr (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(q0rdy[0]), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(q1rdy[0]), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .rsp0_valid(q0vld[0]), .rsp0_ready(rsp0_ready), .rsp1_valid(q1vld[0]), .rsp1_ready(rsp1_ready),
        .rsp_result(qres[0]), .rsp_zero(qzero[0]), .rsp_err(qerr[0])
    );

    alu_arbiter #(.FIXED_PRIO(1)) dut_fp (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(q0rdy[1]), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(q1rdy[1]), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .rsp0_valid(q0vld[1]), .rsp0_ready(rsp0_ready), .rsp1_valid(q1vld[1]), .rsp1_ready(rsp1_ready),
        .rsp_result(qres[1]), .rsp_zero(qzero[1]), .rsp_err(qerr[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic alu_ref(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                           output logic [31:0] r, output bit e);
        e = 1'b0;
        case (op)
            3'b000:  r = a + b;
            3'b100:  r = a - b;
            3'b010:  r = a | b;
            3'b110:  r = (a < b) ? 32'd1 : 32'd0;
            default: begin r = 32'd0; e = 1'b1; end
        endcase
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_busy[d] = 0; m_own[d] = 0; m_lastg[d] = 1;
            m_res[d] = 32'd0; m_zero[d] = 1; m_err[d] = 0;
        end
    endtask

    // Build 1 is fixed priority; build 0 gives a tie to whichever port did not win last.
    function automatic int exp_grant(int d);
        if (m_busy[d]) return -1;
        if (req0_valid && req1_valid) return (d == 1 || m_lastg[d] == 1) ? 0 : 1;
        if (req0_valid) return 0;
        if (req1_valid) return 1;
        return -1;
    endfunction

    task automatic check_all();
        for (int d = 0; d < 2; d++) begin
            int g;
            logic [37:0] e, o;
            g = exp_grant(d);
            e = {(g == 0), (g == 1), (m_busy[d] && m_own[d] == 0), (m_busy[d] && m_own[d] == 1),
                 m_res[d], m_zero[d], m_err[d]};
            o = {q0rdy[d], q1rdy[d], q0vld[d], q1vld[d], qres[d], qzero[d], qerr[d]};
            chk($sformatf("%s/dut%0d", phase, d), 64'(o), 64'(e));
            lastobs[d] = q0rdy[d] ? 0 : (q1rdy[d] ? 1 : -1);
        end
    endtask

    task automatic model_step();
        for (int d = 0; d < 2; d++) begin
            int g;
            logic [31:0] r;
            bit e;
            g = exp_grant(d);
            if (m_busy[d]) begin
                if (m_own[d] == 1 ? rsp1_ready : rsp0_ready) m_busy[d] = 0;
            end else if (g >= 0) begin
                if (g == 1) alu_ref(req1_a, req1_b, req1_op, r, e);
                else        alu_ref(req0_a, req0_b, req0_op, r, e);
                m_busy[d] = 1; m_own[d] = g; m_lastg[d] = g;
                m_res[d] = r; m_zero[d] = (r == 32'd0); m_err[d] = e;
            end
        end
    endtask

    task automatic sample();
        @(negedge clk);
        check_all();
    endtask

    task automatic advance();
        model_step();
        @(posedge clk);
        #1;
    endtask

    // Issues one op on port p and stops at the sample point of the cycle holding its result.
    task automatic do_op(input int p, input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
        req0_valid = (p == 0); req1_valid = (p == 1);
        if (p == 0) begin req0_a = a; req0_b = b; req0_op = op; end
        else        begin req1_a = a; req1_b = b; req1_op = op; end
        sample();
        chk($sformatf("%s/accept_ready", phase), 64'(p == 0 ? q0rdy[0] : q1rdy[0]), 64'd1);
        advance();
        req0_valid = 0; req1_valid = 0;
        sample();
    endtask

    task automatic chk_rsp(input int p, input logic [31:0] res, input bit z, input bit e);
        for (int d = 0; d < 2; d++)
            chk($sformatf("%s/rsp/dut%0d", phase, d),
                64'({q0vld[d], q1vld[d], qres[d], qzero[d], qerr[d]}),
                64'({(p == 0), (p == 1), res, z, e}));
    endtask

    function automatic logic [31:0] rnd32();
        case ($urandom_range(0, 3))
            0:       return 32'd0;
            1:       return 32'($urandom_range(0, 4));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int acc0 [$];
        int acc1 [$];
        rst_n = 0;
        req0_valid = 0; req1_valid = 0;
        req0_a = 0; req0_b = 0; req0_op = 0;
        req1_a = 0; req1_b = 0; req1_op = 0;
        rsp0_ready = 1; rsp1_ready = 1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        phase = "reset";
        for (int d = 0; d < 2; d++)
            chk($sformatf("reset_state/dut%0d", d),
                64'({q0rdy[d], q1rdy[d], q0vld[d], q1vld[d], qres[d], qzero[d], qerr[d]}),
                64'({1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0}));
        rst_n = 1;

        phase = "add_p0";   do_op(0, 32'd5, 32'd3, 3'b000); chk_rsp(0, 32'd8, 0, 0); advance();
        phase = "sub_p1";   do_op(1, 32'd3, 32'd5, 3'b100); chk_rsp(1, 32'hFFFF_FFFE, 0, 0); advance();
        phase = "sub_zero"; do_op(1, 32'd3, 32'd3, 3'b100); chk_rsp(1, 32'd0, 1, 0); advance();
        phase = "sltu_big"; do_op(0, 32'hFFFF_FFFF, 32'd1, 3'b110); chk_rsp(0, 32'd0, 1, 0); advance();
        phase = "sltu_lt";  do_op(1, 32'd1, 32'd2, 3'b110); chk_rsp(1, 32'd1, 0, 0); advance();
        phase = "or";       do_op(0, 32'hF0, 32'h0F, 3'b010); chk_rsp(0, 32'hFF, 0, 0); advance();
        phase = "illegal";  do_op(1, 32'd9, 32'd4, 3'b111); chk_rsp(1, 32'd0, 1, 1); advance();

        // Asynchronous reset while a result is held.
        phase = "rst_mid";
        do_op(0, 32'd7, 32'd1, 3'b000);
        chk_rsp(0, 32'd8, 0, 0);
        rst_n = 0;
        #1;
        for (int d = 0; d < 2; d++)
            chk($sformatf("rst_async/dut%0d", d),
                64'({q0vld[d], q1vld[d], qres[d], qzero[d], qerr[d]}),
                64'({1'b0, 1'b0, 32'd0, 1'b1, 1'b0}));
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1;

        // Both ports hammering with responses always consumed.
        phase = "tie";
        req0_valid = 1; req1_valid = 1;
        req0_a = 32'd10; req0_b = 32'd1; req0_op = 3'b000;
        req1_a = 32'd20; req1_b = 32'd2; req1_op = 3'b100;
        for (int i = 0; i < 8; i++) begin
            sample();
            if (lastobs[0] >= 0) acc0.push_back(lastobs[0]);
            if (lastobs[1] >= 0) acc1.push_back(lastobs[1]);
            advance();
        end
        chk("tie_rr_count", 64'(acc0.size()), 64'd4);
        chk("tie_fp_count", 64'(acc1.size()), 64'd4);
        for (int k = 0; k < 4 && k < acc0.size(); k++) chk($sformatf("tie_rr_seq%0d", k), 64'(acc0[k]), 64'(k % 2));
        for (int k = 0; k < 4 && k < acc1.size(); k++) chk($sformatf("tie_fp_seq%0d", k), 64'(acc1[k]), 64'd0);
        req0_valid = 0; req1_valid = 0;
        sample();
        advance();

        // Port 0 holds its result while port 1 waits.
        phase = "hold";
        do_op(0, 32'h1234_0000, 32'h0000_5678, 3'b000);
        chk_rsp(0, 32'h1234_5678, 0, 0);
        rsp0_ready = 0; req1_valid = 1;
        req1_a = 32'd6; req1_b = 32'd2; req1_op = 3'b010;
        for (int i = 0; i < 5; i++) begin
            advance();
            req0_a = $urandom;
            sample();
            for (int d = 0; d < 2; d++)
                chk($sformatf("hold%0d/dut%0d", i, d), 64'({q1rdy[d], q0vld[d], qres[d]}),
                    64'({1'b0, 1'b1, 32'h1234_5678}));
        end
        rsp0_ready = 1;
        advance();
        rsp0_ready = 0;
        sample();
        for (int d = 0; d < 2; d++)
            chk($sformatf("hold_release/dut%0d", d), 64'({q1rdy[d], q0vld[d]}), 64'({1'b1, 1'b0}));
        advance();
        req1_valid = 0;
        sample();
        chk_rsp(1, 32'd6, 0, 0);
        rsp0_ready = 1; rsp1_ready = 1;
        advance();

        phase = "random";
        for (int i = 0; i < 400; i++) begin
            req0_valid = ($urandom_range(0, 3) != 0);
            req1_valid = ($urandom_range(0, 3) != 0);
            req0_a = rnd32(); req0_b = rnd32(); req0_op = 3'($urandom);
            req1_a = rnd32(); req1_b = rnd32(); req1_op = 3'($urandom);
            rsp0_ready = 1'($urandom);
            rsp1_ready = 1'($urandom);
            sample();
            advance();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
